// File: rtl/data_memory_responder_if.sv
// ---------------------------------------------------------------------------
// data_memory_responder_if
//
// Purpose: groups the request and response valid/ready channels between the
// pipeline memory stage (master) and the data memory responder (slave).
//
// Signals:
//   req_valid    master -> slave   request present this cycle
//   req_ready    slave  -> master  responder can accept a request
//   req_addr     master -> slave   32-bit byte address
//   req_wdata    master -> slave   32-bit store data
//   req_is_store master -> slave   1 = store, 0 = load
//   resp_valid   slave  -> master  response present
//   resp_ready   master -> slave   memory stage accepts the response
//   resp_rdata   slave  -> master  load data (0 for stores and errors)
//   resp_err     slave  -> master  misaligned or out-of-range request
// ---------------------------------------------------------------------------
interface data_memory_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_is_store;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_addr, req_wdata, req_is_store, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_addr, req_wdata, req_is_store, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/data_memory_responder.sv
// ---------------------------------------------------------------------------
// data_memory_responder
//
// Purpose: multi-cycle data memory behind the pipeline memory stage. Accepts
// one load/store at a time, waits a configurable number of cycles, performs
// the access on a word-organized array and returns one response per request.
//
// Parameters:
//   DEPTH_WORDS  number of 32-bit words (power of two, >= 4)
//   LATENCY      cycles from request acceptance to response valid (>= 1)
//
// Ports:
//   clk    single clock, rising edge
//   reset  asynchronous active-high; clears state, outputs and the array
//   bus    slave side of data_memory_responder_if (request/response channels)
// ---------------------------------------------------------------------------
module data_memory_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    data_memory_responder_if.slave  bus
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = $clog2(LATENCY) + 1;
    // With LATENCY=1 the counter is never used, so its load value is moot.
    localparam logic [CW-1:0] CNT_LOAD = (LATENCY > 1) ? CW'(LATENCY - 2) : '0;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [31:0]    addr_q, addr_d;
    logic [31:0]    wdata_q, wdata_d;
    logic           isStore_q, isStore_d;
    logic [31:0]    rdata_q, rdata_d;
    logic           err_q, err_d;

    logic [31:0]    mem_q [DEPTH_WORDS];

    logic           doAccess;
    logic           memWe;
    logic [31:0]    accAddr;
    logic [31:0]    accWdata;
    logic           accStore;
    logic [AW-1:0]  accIdx;
    logic           accErr;

    // The access uses the captured request, except with LATENCY=1 where the
    // commit edge is the accept edge and the live request must be used.
    always_comb begin
        if (LATENCY == 1) begin
            accAddr  = bus.req_addr;
            accWdata = bus.req_wdata;
            accStore = bus.req_is_store;
        end else begin
            accAddr  = addr_q;
            accWdata = wdata_q;
            accStore = isStore_q;
        end
        accIdx = accAddr[AW+1:2];
        // Any address bit above the array's byte range marks out of range.
        accErr = (accAddr[1:0] != 2'b00) || (|accAddr[31:AW+2]);
    end

    // Next-state and datapath control. Outputs are held in registers so the
    // response stays frozen while the memory stage stalls.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        isStore_d = isStore_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        doAccess  = 1'b0;
        memWe     = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    addr_d    = bus.req_addr;
                    wdata_d   = bus.req_wdata;
                    isStore_d = bus.req_is_store;
                    if (LATENCY == 1) begin
                        doAccess = 1'b1;
                        state_d  = RESP;
                    end else begin
                        cnt_d   = CNT_LOAD;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    doAccess = 1'b1;
                    state_d  = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                if (bus.resp_ready) begin
                    rdata_d = '0;
                    err_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (doAccess) begin
            if (accErr) begin
                rdata_d = '0;
                err_d   = 1'b1;
            end else if (accStore) begin
                memWe   = 1'b1;
                rdata_d = '0;
                err_d   = 1'b0;
            end else begin
                rdata_d = mem_q[accIdx];
                err_d   = 1'b0;
            end
        end
    end

    // Control and response registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            isStore_q <= 1'b0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            isStore_q <= isStore_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
        end
    end

    // Data array. Reset clears every word, so a store interrupted by reset
    // before its commit edge leaves no trace.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (memWe) begin
            mem_q[accIdx] <= accWdata;
        end
    end

    assign bus.req_ready  = (state_q == IDLE);
    assign bus.resp_valid = (state_q == RESP);
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;

endmodule

// File: tb/tb_data_memory_responder.sv
// ---------------------------------------------------------------------------
// tb_data_memory_responder
//
// Purpose: directed self-checking bench for data_memory_responder. Three
// instances (LATENCY 3, 1 and 4) share the clock and reset and are exercised
// one after another from a single initial block.
// ---------------------------------------------------------------------------
module tb_data_memory_responder;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    data_memory_responder_if if3 ();
    data_memory_responder_if if1 ();
    data_memory_responder_if if4 ();

    data_memory_responder #(.DEPTH_WORDS(256), .LATENCY(3)) dut3 (
        .clk   (clk),
        .reset (reset),
        .bus   (if3.slave)
    );

    data_memory_responder #(.DEPTH_WORDS(256), .LATENCY(1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (if1.slave)
    );

    data_memory_responder #(.DEPTH_WORDS(256), .LATENCY(4)) dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (if4.slave)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic checkBit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    // Issue one request on the LATENCY=3 instance and check exact response
    // timing and contents; optionally complete the response handshake.
    task automatic applyStimulus(input string tag, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic isStore,
                                 input logic [31:0] expRdata, input logic expErr,
                                 input logic doHandshake);
        if3.req_addr     = addr;
        if3.req_wdata    = wdata;
        if3.req_is_store = isStore;
        if3.req_valid    = 1'b1;
        checkBit({tag, "_ready_before"}, if3.req_ready, 1'b1);
        tick();
        if3.req_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checkBit({tag, "_valid_early"}, if3.resp_valid, 1'b0);
            checkBit({tag, "_ready_busy"}, if3.req_ready, 1'b0);
            tick();
        end
        checkBit({tag, "_valid"}, if3.resp_valid, 1'b1);
        checkOutput({tag, "_rdata"}, if3.resp_rdata, expRdata);
        checkBit({tag, "_err"}, if3.resp_err, expErr);
        if (doHandshake) begin
            if3.resp_ready = 1'b1;
            tick();
            if3.resp_ready = 1'b0;
            checkBit({tag, "_valid_after"}, if3.resp_valid, 1'b0);
            checkBit({tag, "_ready_after"}, if3.req_ready, 1'b1);
        end
    endtask

    initial begin
        int n;
        errors = 0;
        checks = 0;
        reset  = 1'b1;
        if3.req_valid = 1'b0; if3.req_addr = '0; if3.req_wdata = '0;
        if3.req_is_store = 1'b0; if3.resp_ready = 1'b0;
        if1.req_valid = 1'b0; if1.req_addr = '0; if1.req_wdata = '0;
        if1.req_is_store = 1'b0; if1.resp_ready = 1'b0;
        if4.req_valid = 1'b0; if4.req_addr = '0; if4.req_wdata = '0;
        if4.req_is_store = 1'b0; if4.resp_ready = 1'b0;
        $display("[TB] starting data_memory_responder bench");

        // Reset state.
        tick();
        tick();
        checkBit("rst_req_ready", if3.req_ready, 1'b1);
        checkBit("rst_resp_valid", if3.resp_valid, 1'b0);
        checkOutput("rst_rdata", if3.resp_rdata, 32'h0);
        checkBit("rst_err", if3.resp_err, 1'b0);
        reset = 1'b0;
        tick();

        // Load after store, LATENCY=3.
        applyStimulus("st10", 32'h10, 32'hDEADBEEF, 1'b1, 32'h0, 1'b0, 1'b1);
        applyStimulus("ld10", 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, 1'b0, 1'b1);

        // Misaligned and out-of-range stores must not disturb the array.
        applyStimulus("st13", 32'h13, 32'hBADBAD01, 1'b1, 32'h0, 1'b1, 1'b1);
        applyStimulus("st400", 32'h400, 32'hBADBAD02, 1'b1, 32'h0, 1'b1, 1'b1);
        applyStimulus("ld10b", 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, 1'b0, 1'b1);
        applyStimulus("ld0", 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        applyStimulus("ld11", 32'h11, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1);

        // Last in-range word.
        applyStimulus("st3fc", 32'h3FC, 32'h55AA55AA, 1'b1, 32'h0, 1'b0, 1'b1);
        applyStimulus("ld3fc", 32'h3FC, 32'h0, 1'b0, 32'h55AA55AA, 1'b0, 1'b1);

        // Response backpressure; a request held during the stall is ignored.
        applyStimulus("ldbp", 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0);
        if3.req_valid    = 1'b1;
        if3.req_addr     = 32'h3FC;
        if3.req_is_store = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checkBit("bp_valid", if3.resp_valid, 1'b1);
            checkOutput("bp_rdata", if3.resp_rdata, 32'hDEADBEEF);
            checkBit("bp_err", if3.resp_err, 1'b0);
            checkBit("bp_ready", if3.req_ready, 1'b0);
        end
        if3.req_valid  = 1'b0;
        if3.resp_ready = 1'b1;
        tick();
        if3.resp_ready = 1'b0;
        checkBit("bp_done_valid", if3.resp_valid, 1'b0);
        checkBit("bp_done_ready", if3.req_ready, 1'b1);
        checkOutput("bp_done_rdata", if3.resp_rdata, 32'h0);
        applyStimulus("ld3fc_keep", 32'h3FC, 32'h0, 1'b0, 32'h55AA55AA, 1'b0, 1'b1);

        // LATENCY=1 streaming with req_valid and resp_ready tied high.
        if1.req_valid  = 1'b1;
        if1.resp_ready = 1'b1;
        if1.req_is_store = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if1.req_addr  = 32'(k * 4);
            if1.req_wdata = 32'hA5000000 | 32'(k);
            checkBit("l1st_ready", if1.req_ready, 1'b1);
            tick();
            checkBit("l1st_valid", if1.resp_valid, 1'b1);
            checkOutput("l1st_rdata", if1.resp_rdata, 32'h0);
            checkBit("l1st_err", if1.resp_err, 1'b0);
            tick();
            checkBit("l1st_gap", if1.resp_valid, 1'b0);
        end
        if1.req_is_store = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if1.req_addr = 32'(k * 4);
            checkBit("l1ld_ready", if1.req_ready, 1'b1);
            tick();
            checkBit("l1ld_valid", if1.resp_valid, 1'b1);
            checkOutput("l1ld_rdata", if1.resp_rdata, 32'hA5000000 | 32'(k));
            checkBit("l1ld_busy", if1.req_ready, 1'b0);
            if (k == 3) if1.req_valid = 1'b0;
            tick();
            checkBit("l1ld_gap", if1.resp_valid, 1'b0);
        end
        if1.resp_ready = 1'b0;

        // LATENCY=4: a completed store, exact latency, then reset mid-store.
        if4.req_addr     = 32'h20;
        if4.req_wdata    = 32'hCAFEF00D;
        if4.req_is_store = 1'b1;
        if4.req_valid    = 1'b1;
        tick();
        if4.req_valid = 1'b0;
        n = 0;
        while (!if4.resp_valid && n < 20) begin
            tick();
            n++;
        end
        checkOutput("l4_latency", 32'(n), 32'd3);
        if4.resp_ready = 1'b1;
        tick();
        if4.resp_ready = 1'b0;

        if4.req_wdata = 32'h12345678;
        if4.req_valid = 1'b1;
        tick();
        if4.req_valid = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        #1;
        checkBit("l4rst_ready", if4.req_ready, 1'b1);
        checkBit("l4rst_valid", if4.resp_valid, 1'b0);
        checkOutput("l4rst_rdata", if4.resp_rdata, 32'h0);
        checkBit("l4rst_err", if4.resp_err, 1'b0);
        tick();
        reset = 1'b0;
        tick();
        checkBit("l4rel_ready", if4.req_ready, 1'b1);

        if4.req_is_store = 1'b0;
        if4.req_valid    = 1'b1;
        tick();
        if4.req_valid = 1'b0;
        n = 0;
        while (!if4.resp_valid && n < 20) begin
            tick();
            n++;
        end
        checkOutput("l4ld_latency", 32'(n), 32'd3);
        checkOutput("l4ld_rdata", if4.resp_rdata, 32'h0);
        checkBit("l4ld_err", if4.resp_err, 1'b0);
        if4.resp_ready = 1'b1;
        tick();
        if4.resp_ready = 1'b0;
        checkBit("l4ld_done", if4.req_ready, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
